// File: rtl/seq_slice_adder_pkg.sv
// Shared definitions for the sequential slice adder: FSM encoding and
// default operand/slice widths.
package seq_slice_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca.sv
// 4-bit ripple-carry slice. The carry chain is purely combinational;
// c3 is the carry out of bit 3.
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       c3,
  output logic [3:0] S
);

  logic [4:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upwards.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign S[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c3 = c[4];

endmodule

// File: rtl/seq_slice_adder_slice.sv
// Combinational W-bit slice adder. Uses the 4-bit rca for the common
// W=4 case and a plain behavioural ripple add for any other width.
module seq_slice_adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         cout,
  output logic [W-1:0] s
);

  if (W == 4) begin : g_rca
    rca u_rca (
      .a   (a),
      .b   (b),
      .cin (cin),
      .c3  (cout),
      .S   (s)
    );
  end else begin : g_generic
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit slice adder is reused over
// NSLICE cycles, least-significant slice first, with a registered carry
// linking consecutive slices.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Request side: in_ready is high only in IDLE; a, b, cin are
// captured on the accepting edge and ignored otherwise. Result side:
// out_valid rises in DONE and stays high, with sum/cout/ovf stable, until
// the edge where out_ready is also high.
module seq_slice_adder
  import seq_slice_adder_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int SLICE  = DEF_SLICE,
  localparam int NSLICE = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int              IDXW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [SLICE-1:0]  slice_a_d;
  logic [SLICE-1:0]  slice_b_d;
  logic [SLICE-1:0]  slice_s_d;
  logic              slice_c_d;
  logic              msb_carry_d;

  // Select the operand slice for the current step.
  assign slice_a_d = a_q[idx_q*SLICE +: SLICE];
  assign slice_b_d = b_q[idx_q*SLICE +: SLICE];

  // Carry into the MSB, recovered from the MSB sum bit; only meaningful
  // while the final slice is being processed.
  assign msb_carry_d = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s_d[SLICE-1];

  seq_slice_adder_slice #(
    .W (SLICE)
  ) u_slice (
    .a    (slice_a_d),
    .b    (slice_b_d),
    .cin  (carry_q),
    .cout (slice_c_d),
    .s    (slice_s_d)
  );

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            sum_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*SLICE +: SLICE] <= slice_s_d;
          carry_q                     <= slice_c_d;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_c_d;
            ovf_q       <= msb_carry_d ^ slice_c_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: doc/seq_slice_adder.md
Name: seq_slice_adder

Overview:
- Multi-cycle WIDTH-bit adder built by iterating one SLICE-bit ripple-carry slice over the operand, least-significant slice first.
- A registered carry links each cycle's slice to the next.
- Upstream producers use a valid/ready request channel; downstream consumers use a valid/ready result channel.
- Trades latency for area: one slice adder replaces WIDTH/SLICE slices.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, width of the combinational adder slice processed per cycle.
- NSLICE, WIDTH/SLICE, number of compute cycles (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to slice 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow (carry into MSB xor cout).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, idx=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0. in_ready is 1 from the first edge after rst deasserts.
- Reset mid-operation aborts the RUN or DONE state. The pending result is discarded with no out_valid pulse, and all outputs return to their reset values.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin into operand registers, clear sum, set idx=0, go to RUN.
  - RUN: in_ready=0. Each cycle, feed operand slice idx and the carry reg to the slice adder. Write the slice result into sum[idx*SLICE +: SLICE] and store the slice carry-out in the carry reg.
    - On idx=NSLICE-1: also capture cout, compute ovf from the carry into bit WIDTH-1 xor cout, go to DONE.
    - Otherwise: idx++.
  - DONE: out_valid=1; sum, cout and ovf held stable. On out_valid&out_ready, go to IDLE and drop out_valid.
- Latency: the accept edge is edge 0. out_valid is high after edge NSLICE (4 for the defaults).
- Throughput: at most one request per NSLICE+2 cycles, because in_ready is low in RUN and DONE. Requests are never overlapped.
- Input changes while in_ready=0 are ignored. The operand registers isolate the computation from a, b and cin after accept.
- sum, cout and ovf keep their last values after the DONE handshake until the next accept clears sum.
- Arithmetic: unsigned modulo 2^WIDTH for sum. cout is the unsigned carry. ovf holds the signed interpretation.
- The slice carry path is purely combinational within one cycle. No carry lookahead.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE) and the default WIDTH/SLICE constants.
- One sub-module: the existing 4-bit ripple-carry slice rca, instantiated once with ports a, b, cin, c3, S.
- For SLICE≠4, provide a generic slice_adder of parameterised width with the same port roles.
- The carry into the MSB, needed for ovf, is computed locally as a[MSB]^b[MSB]^sum[MSB] on the final slice.

Test Plan:
- Basic add: a=0x1234, b=0x4321, cin=0, out_ready=1 -> after 4 cycles, sum=0x5555, cout=0, ovf=0. out_valid high exactly one cycle, then in_ready=1.
- Full carry ripple across all slices: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> same result.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure and input isolation: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stay stable and in_ready=0. A new in_valid with different a/b during RUN/DONE is not accepted and does not alter the result. The next request is accepted only after the result handshake.
- Reset mid-operation: assert rst for 1 cycle at RUN idx=2 -> next cycle all outputs at reset values and no out_valid. A following request 0x0F0F+0x00F1 gives sum=0x1000, cout=0.
- Back-to-back: two requests offered continuously with in_valid held high -> second accepted the cycle after the first result handshake. Each result is correct, with 4-cycle latency from its own accept.
